// File: rtl/ins_buf_pkg.sv
// Shared constants, types and helpers for the instruction-buffer dispatch controller.
package ins_buf_pkg;

  localparam int DEPTH           = 16;
  localparam int ADDR_W          = 5;
  localparam int OCC_W           = $clog2(DEPTH) + 1;
  localparam int STALL_EXIT_FREE = 4;
  localparam int FLUSH_CYCLES    = 2;

  typedef logic [ADDR_W-1:0] slot_addr_t;
  typedef logic [OCC_W-1:0]  occ_t;

  localparam slot_addr_t NO_SLOT = 5'd31;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } disp_state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/ins_grant_prefix.sv
// In-order 4-lane grant selection with prefix-sum slot addressing.
// A free budget of zero suppresses every grant and leaves all lanes at NO_SLOT.
module ins_grant_prefix
  import ins_buf_pkg::*;
(
  input  logic [3:0]  ins_new_vld,
  input  logic [4:0]  base,
  input  logic [4:0]  free,
  output logic [3:0]  ins_grant,
  output logic [19:0] ins_new_addr
);

  logic [2:0] taken_s;
  logic       blocked_s;

  // Walk lanes oldest-first; the first valid lane that misses blocks all younger lanes.
  always_comb begin
    taken_s      = 3'd0;
    blocked_s    = 1'b0;
    ins_grant    = 4'b0000;
    ins_new_addr = {4{NO_SLOT}};
    for (int i = 0; i < 4; i++) begin
      if (ins_new_vld[i] && !blocked_s && ({2'b00, taken_s} < free)) begin
        ins_grant[i]            = 1'b1;
        ins_new_addr[i*5 +: 5]  = base + {2'b00, taken_s};
        taken_s                 = taken_s + 3'd1;
      end else begin
        blocked_s = blocked_s | ins_new_vld[i];
      end
    end
  end

endmodule

// File: rtl/ins_buffer_dispatch_ctrl.sv
// Dispatch controller for the 16-entry collapsing instruction buffer: grants,
// slot addresses, occupancy tracking, stall and post-flush recovery.
module ins_buffer_dispatch_ctrl
  import ins_buf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [3:0]  ins_new_vld,
  input  logic [3:0]  ins_out,
  output logic [3:0]  ins_grant,
  output logic [19:0] ins_new_addr,
  output logic        stall,
  output logic [4:0]  occupancy,
  output logic        full,
  output logic        empty,
  output logic        underflow_err
);

  localparam occ_t       DEPTH_C    = 5'd16;
  localparam occ_t       EXIT_C     = 5'd4;
  localparam logic [1:0] CNT_LOAD_C = 2'd1;

  disp_state_t state_r, state_next_s;
  occ_t        occupancy_r, occ_next_s;
  logic [1:0]  flush_cnt_r, flush_cnt_next_s;
  logic        stall_r;
  logic        underflow_err_r;

  logic [2:0]  out_sum_s;
  occ_t        out_eff_s;
  logic        underflow_s;
  occ_t        base_s;
  occ_t        free_s;
  occ_t        free_eff_s;
  logic        grant_en_s;
  logic [3:0]  grant_s;
  logic        blocked_s;

  // Issued-entry count, clamped to occupancy so the counter can never wrap.
  always_comb begin
    if (state_r == FLUSH) begin
      out_sum_s = 3'd0;
    end else begin
      out_sum_s = popcount4(ins_out);
    end
    if ({2'b00, out_sum_s} > occupancy_r) begin
      underflow_s = 1'b1;
      out_eff_s   = occupancy_r;
    end else begin
      underflow_s = 1'b0;
      out_eff_s   = {2'b00, out_sum_s};
    end
    base_s = occupancy_r - out_eff_s;
    free_s = DEPTH_C - base_s;
  end

  // Grants are only offered in RUN, outside reset and with no flush pending.
  always_comb begin
    grant_en_s = rst_n && !flush && (state_r == RUN);
    if (grant_en_s) begin
      free_eff_s = free_s;
    end else begin
      free_eff_s = 5'd0;
    end
  end

  ins_grant_prefix u_grant_prefix (
    .ins_new_vld  (ins_new_vld),
    .base         (base_s),
    .free         (free_eff_s),
    .ins_grant    (grant_s),
    .ins_new_addr (ins_new_addr)
  );

  assign blocked_s = |(ins_new_vld & ~grant_s);

  // Next state, next occupancy and flush-recovery counter.
  always_comb begin
    state_next_s     = state_r;
    occ_next_s       = occupancy_r;
    flush_cnt_next_s = flush_cnt_r;
    if (flush) begin
      state_next_s     = FLUSH;
      occ_next_s       = 5'd0;
      flush_cnt_next_s = CNT_LOAD_C;
    end else begin
      case (state_r)
        RUN: begin
          occ_next_s = base_s + {2'b00, popcount4(grant_s)};
          if (blocked_s) begin
            state_next_s = STALL;
          end else begin
            state_next_s = RUN;
          end
        end
        STALL: begin
          occ_next_s = base_s;
          if ((DEPTH_C - base_s) >= EXIT_C) begin
            state_next_s = RUN;
          end else begin
            state_next_s = STALL;
          end
        end
        FLUSH: begin
          occ_next_s = 5'd0;
          if (flush_cnt_r == 2'd0) begin
            state_next_s = RUN;
          end else begin
            flush_cnt_next_s = flush_cnt_r - 2'd1;
          end
        end
        default: begin
          state_next_s     = RUN;
          occ_next_s       = 5'd0;
          flush_cnt_next_s = 2'd0;
        end
      endcase
    end
  end

  // State register; stall tracks whether the next state withholds grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      stall_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      stall_r <= (state_next_s != RUN);
    end
  end

  // Occupancy, flush counter and sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy_r     <= 5'd0;
      flush_cnt_r     <= 2'd0;
      underflow_err_r <= 1'b0;
    end else begin
      occupancy_r     <= occ_next_s;
      flush_cnt_r     <= flush_cnt_next_s;
      underflow_err_r <= underflow_err_r | underflow_s;
    end
  end

  assign ins_grant     = grant_s;
  assign stall         = stall_r;
  assign occupancy     = occupancy_r;
  assign full          = (occupancy_r == DEPTH_C);
  assign empty         = (occupancy_r == 5'd0);
  assign underflow_err = underflow_err_r;

endmodule

// File: tb/tb_ins_buffer_dispatch_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_ins_buffer_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  ins_new_vld;
  logic [3:0]  ins_out;
  logic [3:0]  ins_grant;
  logic [19:0] ins_new_addr;
  logic        stall;
  logic [4:0]  occupancy;
  logic        full;
  logic        empty;
  logic        underflow_err;

  int checks = 0;
  int errors = 0;

  // Behavioural model: occupancy as an int, mode 0=run 1=stall 2=flush recovery.
  int   m_occ, m_mode, m_cnt;
  bit   m_err;
  logic [3:0]  exp_g;
  logic [19:0] exp_a;
  int   exp_n, exp_base;
  bit   exp_blk, exp_uf;
  logic [3:0]  g_seen;
  logic [19:0] a_seen;

  always #5 clk = ~clk;

  ins_buffer_dispatch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .ins_new_vld   (ins_new_vld),
    .ins_out       (ins_out),
    .ins_grant     (ins_grant),
    .ins_new_addr  (ins_new_addr),
    .stall         (stall),
    .occupancy     (occupancy),
    .full          (full),
    .empty         (empty),
    .underflow_err (underflow_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_comb(input logic [3:0] vld, input logic [3:0] outv, input bit fl);
    int outs;
    int free;
    outs = (m_mode == 2) ? 0 : $countones(outv);
    exp_uf = (outs > m_occ);
    if (exp_uf) outs = m_occ;
    exp_base = m_occ - outs;
    free     = 16 - exp_base;
    exp_g   = 4'b0000;
    exp_a   = '1;
    exp_n   = 0;
    exp_blk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (vld[i]) begin
        if (!exp_blk && m_mode == 0 && !fl && exp_n < free) begin
          exp_g[i]       = 1'b1;
          exp_a[i*5 +: 5] = 5'(exp_base + exp_n);
          exp_n++;
        end else begin
          exp_blk = 1'b1;
        end
      end
    end
  endfunction

  function automatic void model_clock(input bit fl);
    m_err = m_err | exp_uf;
    if (fl) begin
      m_occ = 0; m_mode = 2; m_cnt = 1;
    end else if (m_mode == 0) begin
      m_occ  = exp_base + exp_n;
      m_mode = exp_blk ? 1 : 0;
    end else if (m_mode == 1) begin
      m_occ = exp_base;
      if (16 - m_occ >= 4) m_mode = 0;
    end else begin
      m_occ = 0;
      if (m_cnt == 0) m_mode = 0;
      else m_cnt--;
    end
  endfunction

  task automatic step(input logic [3:0] vld, input logic [3:0] outv, input bit fl);
    @(negedge clk);
    ins_new_vld = vld;
    ins_out     = outv;
    flush       = fl;
    #1;
    model_comb(vld, outv, fl);
    g_seen = ins_grant;
    a_seen = ins_new_addr;
    check_eq("grant", ins_grant, exp_g);
    check_eq("addr", ins_new_addr, exp_a);
    @(posedge clk);
    model_clock(fl);
    #1;
    check_eq("occ", occupancy, m_occ);
    check_eq("stall", stall, (m_mode != 0));
    check_eq("full", full, (m_occ == 16));
    check_eq("empty", empty, (m_occ == 0));
    check_eq("uf_err", underflow_err, m_err);
  endtask

  task automatic do_reset();
    ins_new_vld = 4'hF;
    ins_out     = 4'h0;
    flush       = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_grant", ins_grant, 4'h0);
    check_eq("rst_addr", ins_new_addr, 20'hFFFFF);
    check_eq("rst_occ", occupancy, 5'd0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_empty", empty, 1'b1);
    check_eq("rst_err", underflow_err, 1'b0);
    m_occ = 0; m_mode = 0; m_cnt = 0; m_err = 1'b0;
    ins_new_vld = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rv, ro;
    bit         rf;
    rst_n = 1'b0;
    do_reset();

    // Empty buffer, four requests.
    step(4'hF, 4'h0, 1'b0);
    check_eq("tp1_g", g_seen, 4'hF);
    check_eq("tp1_a", a_seen, {5'd3, 5'd2, 5'd1, 5'd0});
    check_eq("tp1_occ", occupancy, 5'd4);
    step(4'hF, 4'h0, 1'b0);
    step(4'hF, 4'h0, 1'b0);
    step(4'h3, 4'h0, 1'b0);
    check_eq("tp2_occ14", occupancy, 5'd14);

    // Two free slots, sparse request pattern: lane 3 blocked.
    step(4'b1011, 4'h0, 1'b0);
    check_eq("tp2_g", g_seen, 4'b0011);
    check_eq("tp2_a", a_seen, {5'd31, 5'd31, 5'd15, 5'd14});
    check_eq("tp2_stall", stall, 1'b1);
    check_eq("tp2_full", full, 1'b1);

    // Drain out of STALL.
    step(4'h0, 4'b0011, 1'b0);
    check_eq("tp4_occ14", occupancy, 5'd14);
    check_eq("tp4_stall1", stall, 1'b1);
    step(4'h0, 4'b0011, 1'b0);
    check_eq("tp4_occ12", occupancy, 5'd12);
    check_eq("tp4_stall0", stall, 1'b0);

    // Full with same-cycle reclaim.
    step(4'hF, 4'h0, 1'b0);
    check_eq("tp3_full", occupancy, 5'd16);
    step(4'hF, 4'hF, 1'b0);
    check_eq("tp3_g", g_seen, 4'hF);
    check_eq("tp3_a", a_seen, {5'd15, 5'd14, 5'd13, 5'd12});
    check_eq("tp3_occ", occupancy, 5'd16);
    check_eq("tp3_stall", stall, 1'b0);

    // Flush at occupancy 9, then two recovery cycles.
    step(4'h0, 4'hF, 1'b0);
    step(4'h0, 4'b0111, 1'b0);
    check_eq("tp5_occ9", occupancy, 5'd9);
    step(4'hF, 4'h0, 1'b1);
    check_eq("tp5_g0", g_seen, 4'h0);
    check_eq("tp5_occ0", occupancy, 5'd0);
    check_eq("tp5_stall_a", stall, 1'b1);
    step(4'hF, 4'h0, 1'b0);
    check_eq("tp5_stall_b", stall, 1'b1);
    step(4'hF, 4'h0, 1'b0);
    check_eq("tp5_g_rec", g_seen, 4'h0);
    check_eq("tp5_stall_c", stall, 1'b0);
    step(4'hF, 4'h0, 1'b0);
    check_eq("tp5_a", a_seen, {5'd3, 5'd2, 5'd1, 5'd0});

    // Underflow: sticky until reset.
    step(4'h0, 4'b0111, 1'b0);
    step(4'h0, 4'b0111, 1'b0);
    check_eq("tp6_occ", occupancy, 5'd0);
    check_eq("tp6_err", underflow_err, 1'b1);
    step(4'h0, 4'h0, 1'b0);
    check_eq("tp6_sticky", underflow_err, 1'b1);

    // Reset mid-STALL.
    for (int k = 0; k < 5; k++) step(4'hF, 4'h0, 1'b0);
    check_eq("stall_pre_rst", stall, 1'b1);
    do_reset();

    // Reset mid-FLUSH.
    step(4'h0, 4'h0, 1'b1);
    do_reset();

    // Randomized traffic.
    for (int k = 0; k < 800; k++) begin
      rv = 4'($urandom);
      if ($urandom_range(0, 2) == 0) ro = 4'($urandom);
      else ro = 4'($urandom & $urandom & $urandom);
      rf = ($urandom_range(0, 39) == 0);
      step(rv, ro, rf);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
